// File: rtl/lcd_mode_scheduler_pkg.sv
// Shared types and defaults for the LCD mode scheduler and its helpers.
package lcd_mode_scheduler_pkg;

    localparam int unsigned NUM_CHARS  = 32;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        MODE_WATCH = 2'd0,
        MODE_SET   = 2'd1,
        MODE_ALARM = 2'd2,
        MODE_STOP  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StSend  = 2'd2
    } state_e;

    // One-hot request on the low three switches picks modes 1..3; anything else is mode 0.
    function automatic mode_e decode_mode(input logic [3:0] dip_sw);
        mode_e m;
        case (dip_sw)
            4'b0001: m = MODE_SET;
            4'b0010: m = MODE_ALARM;
            4'b0100: m = MODE_STOP;
            default: m = MODE_WATCH;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sw_pulse_router.sv
// Rising-edge detector on the button levels, routed to the active mode block only.
module sw_pulse_router
    import lcd_mode_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    input  mode_e      mode,
    output logic [3:0] sw_pulse0,
    output logic [3:0] sw_pulse1,
    output logic [3:0] sw_pulse2,
    output logic [3:0] sw_pulse3
);

    logic [3:0] prev_q;
    logic [3:0] sw_rise;

    // Previous button levels; all-ones on reset so a button held through reset never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 4'hF;
        end else begin
            prev_q <= sw_in;
        end
    end

    assign sw_rise = sw_in & ~prev_q;

    // Route rises to the committed mode; mode is registered, so a commit cycle still goes old.
    always_comb begin
        sw_pulse0 = 4'b0000;
        sw_pulse1 = 4'b0000;
        sw_pulse2 = 4'b0000;
        sw_pulse3 = 4'b0000;
        case (mode)
            MODE_WATCH: sw_pulse0 = sw_rise;
            MODE_SET:   sw_pulse1 = sw_rise;
            MODE_ALARM: sw_pulse2 = sw_rise;
            MODE_STOP:  sw_pulse3 = sw_rise;
            default:    ;
        endcase
    end

endmodule

// File: rtl/lcd_mode_scheduler.sv
// Frame scheduler: commits the requested mode between frames and streams one frame of
// characters to the LCD driver, blanking the first frame after a mode change.
module lcd_mode_scheduler #(
    parameter int unsigned NUM_CHARS  = lcd_mode_scheduler_pkg::NUM_CHARS,
    parameter logic [7:0]  BLANK_CHAR = lcd_mode_scheduler_pkg::BLANK_CHAR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dip_sw,
    input  logic [3:0] sw_in,
    input  logic [7:0] data_mode0,
    input  logic [7:0] data_mode1,
    input  logic [7:0] data_mode2,
    input  logic [7:0] data_mode3,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [4:0] index_char,
    output logic [3:0] sw_pulse0,
    output logic [3:0] sw_pulse1,
    output logic [3:0] sw_pulse2,
    output logic [3:0] sw_pulse3,
    output logic [1:0] mode,
    output logic       frame_done
);

    import lcd_mode_scheduler_pkg::*;

    localparam logic [4:0] LAST_INDEX = 5'(NUM_CHARS - 1);

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic       blank_q, blank_d;
    // Set by reset so the first frame after reset is never blanked.
    logic       first_q, first_d;
    logic [4:0] index_q, index_d;
    logic [7:0] data_q, data_d;
    logic [7:0] sel_data;
    logic       xfer;
    logic       last_char;

    assign xfer      = (state_q == StSend) && char_ready;
    assign last_char = (index_q == LAST_INDEX);

    // Pick the active mode block's character for the current index.
    always_comb begin
        sel_data = data_mode0;
        case (mode_q)
            MODE_WATCH: sel_data = data_mode0;
            MODE_SET:   sel_data = data_mode1;
            MODE_ALARM: sel_data = data_mode2;
            MODE_STOP:  sel_data = data_mode3;
            default:    sel_data = data_mode0;
        endcase
    end

    // Next-state logic: one IDLE cycle per frame, then FETCH/SEND per character.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        blank_d = blank_q;
        first_d = first_q;
        index_d = index_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                mode_d  = decode_mode(dip_sw);
                blank_d = !first_q && (mode_d != mode_q);
                first_d = 1'b0;
                index_d = 5'd0;
                state_d = StFetch;
            end
            StFetch: begin
                data_d  = blank_q ? BLANK_CHAR : sel_data;
                state_d = StSend;
            end
            StSend: begin
                if (char_ready) begin
                    if (last_char) begin
                        index_d = 5'd0;
                        state_d = StIdle;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= MODE_WATCH;
            blank_q <= 1'b0;
            first_q <= 1'b1;
            index_q <= 5'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
            first_q <= first_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    assign char_valid = (state_q == StSend);
    assign char_data  = data_q;
    assign index_char = index_q;
    assign mode       = mode_q;
    // A reset edge aborts the transfer, so the last-character pulse is suppressed too.
    assign frame_done = xfer && last_char && !rst;

    sw_pulse_router u_sw_pulse_router (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .mode      (mode_q),
        .sw_pulse0 (sw_pulse0),
        .sw_pulse1 (sw_pulse1),
        .sw_pulse2 (sw_pulse2),
        .sw_pulse3 (sw_pulse3)
    );

endmodule
